serializer_valrdy: RTL and testbench

Parametrised val/rdy serializer: accepts a `BITWIDTH`-bit word on a latency-insensitive receive interface and emits it as `BITWIDTH/N_LANES` consecutive `N_LANES`-bit beats on a val/rdy send interface. Shift direction (MSB-first or LSB-first) is selectable per word. It succeeds the single-bit load/shift SISO register in the valrdy library. It feeds narrow links such as SPI, bit-serial arithmetic and off-chip pads from word-wide producers, with full back-to-back throughput.

---
 rtl/serializer_valrdy_if.sv | 44 ++++
 rtl/serializer_valrdy.sv | 97 +++++++++
 tb/tb_serializer_valrdy.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/serializer_valrdy_if.sv
// ============================================================================
// Module   : serializer_valrdy_if
// Brief    : val/rdy receive + send bundle for serializer_valrdy.
//            send_last is present only when SERIALIZER_LAST_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serializer_valrdy_if #(
    parameter int BITWIDTH = 32,
    parameter int N_LANES  = 1
);
    logic [BITWIDTH-1:0] recv_msg;
    logic                recv_val;
    logic                recv_rdy;
    logic                msb_first;
    logic [N_LANES-1:0]  send_msg;
    logic                send_val;
    logic                send_rdy;
`ifdef SERIALIZER_LAST_EN
    logic                send_last;

    // master = the serializer itself, slave = producer/consumer environment
    modport master (
        input  recv_msg, recv_val, msb_first, send_rdy,
        output recv_rdy, send_msg, send_val, send_last
    );
    modport slave (
        output recv_msg, recv_val, msb_first, send_rdy,
        input  recv_rdy, send_msg, send_val, send_last
    );
`else
    modport master (
        input  recv_msg, recv_val, msb_first, send_rdy,
        output recv_rdy, send_msg, send_val
    );
    modport slave (
        output recv_msg, recv_val, msb_first, send_rdy,
        input  recv_rdy, send_msg, send_val
    );
`endif
endinterface

`default_nettype wire

// File: rtl/serializer_valrdy.sv
// ============================================================================
// Module   : serializer_valrdy
// Brief    : Word-to-beat val/rdy serializer, MSB- or LSB-first per word,
//            zero-bubble reload. Optional send_last via SERIALIZER_LAST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serializer_valrdy #(
    parameter int BITWIDTH = 32,
    parameter int N_LANES  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    serializer_valrdy_if.master  bus
);
    localparam int BEATS = BITWIDTH / N_LANES;
    localparam int CW    = $clog2(BEATS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]          state_q,  state_d;
    logic [BITWIDTH-1:0] regval_q, regval_d;
    logic                dir_q,    dir_d;
    logic [CW-1:0]       count_q,  count_d;

    logic [BITWIDTH-1:0] w_shl;
    logic [BITWIDTH-1:0] w_shr;
    logic                w_busy;
    logic                w_last_beat;
    logic                w_recv_fire;
    logic                w_send_fire;

    assign w_busy      = (state_q == BUSY);
    assign w_last_beat = w_busy && (count_q == CW'(1));

    // Ready looks through send_rdy so a new word can load on the last beat.
    assign bus.recv_rdy = ~reset & (~w_busy | (w_last_beat & bus.send_rdy));
    assign w_recv_fire  = bus.recv_val & bus.recv_rdy;
    assign w_send_fire  = w_busy & bus.send_rdy;

    assign bus.send_val = w_busy;
    assign bus.send_msg = dir_q ? regval_q[BITWIDTH-1 -: N_LANES]
                                : regval_q[N_LANES-1:0];
`ifdef SERIALIZER_LAST_EN
    assign bus.send_last = w_last_beat;
`endif

    generate
        if (BEATS > 1) begin : g_shift
            assign w_shl = {regval_q[BITWIDTH-N_LANES-1:0], {N_LANES{1'b0}}};
            assign w_shr = {{N_LANES{1'b0}}, regval_q[BITWIDTH-1:N_LANES]};
        end else begin : g_noshift
            // Single-beat words never shift; the register is always reloaded.
            assign w_shl = '0;
            assign w_shr = '0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        regval_d = regval_q;
        dir_d    = dir_q;
        count_d  = count_q;
        if (w_recv_fire) begin
            state_d  = BUSY;
            regval_d = bus.recv_msg;
            dir_d    = bus.msb_first;
            count_d  = CW'(BEATS);
        end else if (w_send_fire) begin
            if (count_q > CW'(1)) begin
                regval_d = dir_q ? w_shl : w_shr;
                count_d  = count_q - CW'(1);
            end else begin
                state_d = IDLE;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            regval_q <= '0;
            dir_q    <= 1'b1;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            regval_q <= regval_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serializer_valrdy.sv
// ============================================================================
// Module   : tb_serializer_valrdy
// Brief    : Directed bench for serializer_valrdy (8-bit words, 2 and 8 lanes).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serializer_valrdy;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serializer_valrdy_if #(.BITWIDTH(8), .N_LANES(2)) b0 ();
    serializer_valrdy_if #(.BITWIDTH(8), .N_LANES(8)) b1 ();

    serializer_valrdy #(.BITWIDTH(8), .N_LANES(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );
    serializer_valrdy #(.BITWIDTH(8), .N_LANES(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one word to the 2-lane DUT for one cycle; it must be accepted.
    task automatic accept(input string tag, input logic [7:0] msg, input logic dir);
        b0.recv_val  = 1'b1;
        b0.recv_msg  = msg;
        b0.msb_first = dir;
        #1;
        chk({tag, "_acc_rdy"}, b0.recv_rdy, 1);
        tick();
        b0.recv_val = 1'b0;
        b0.recv_msg = 8'h00;
    endtask

    // Four unstalled beats; optionally toggle msb_first to prove it is ignored.
    task automatic beats(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                         input logic [1:0] e2, input logic [1:0] e3, input logic flip);
        logic [1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        b0.send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (flip) b0.msb_first = ~b0.msb_first;
            #1;
            chk($sformatf("%s_val%0d", tag, i), b0.send_val, 1);
            chk($sformatf("%s_msg%0d", tag, i), b0.send_msg, e[i]);
            chk($sformatf("%s_rdy%0d", tag, i), b0.recv_rdy, (i == 3));
`ifdef SERIALIZER_LAST_EN
            chk($sformatf("%s_last%0d", tag, i), b0.send_last, (i == 3));
`endif
            tick();
        end
        #1;
        chk({tag, "_idle_val"}, b0.send_val, 0);
        chk({tag, "_idle_rdy"}, b0.recv_rdy, 1);
    endtask

    initial begin
        reset        = 1'b1;
        b0.recv_msg  = '0; b0.recv_val = 1'b0; b0.msb_first = 1'b1; b0.send_rdy = 1'b0;
        b1.recv_msg  = '0; b1.recv_val = 1'b0; b1.msb_first = 1'b1; b1.send_rdy = 1'b0;
        tick();
        tick();

        // Reset state; ready must stay low while reset is held even if valid.
        b0.recv_val = 1'b1;
        #1;
        chk("rst_rdy",  b0.recv_rdy, 0);
        chk("rst_val",  b0.send_val, 0);
        chk("rst_msg",  b0.send_msg, 0);
        chk("rst_val8", b1.send_val, 0);
`ifdef SERIALIZER_LAST_EN
        chk("rst_last", b0.send_last, 0);
`endif
        b0.recv_val = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", b0.recv_rdy, 1);
        chk("post_rst_val", b0.send_val, 0);

        // MSB-first 0xB4 -> 2,3,1,0
        b0.send_rdy = 1'b1;
        accept("msb", 8'hB4, 1'b1);
        beats("msb", 2'd2, 2'd3, 2'd1, 2'd0, 1'b0);

        // LSB-first 0xB4 -> 0,1,3,2, with msb_first wiggling mid-word
        accept("lsb", 8'hB4, 1'b0);
        beats("lsb", 2'd0, 2'd1, 2'd3, 2'd2, 1'b1);

        // Backpressure: stall three cycles after the first beat
        accept("bp", 8'hB4, 1'b1);
        #1;
        chk("bp_msg0", b0.send_msg, 2);
        tick();
        b0.send_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall_val%0d", i), b0.send_val, 1);
            chk($sformatf("bp_stall_msg%0d", i), b0.send_msg, 3);
            chk($sformatf("bp_stall_rdy%0d", i), b0.recv_rdy, 0);
            tick();
        end
        b0.send_rdy = 1'b1;
        #1;
        chk("bp_msg1", b0.send_msg, 3);
        chk("bp_rdy1", b0.recv_rdy, 0);
        tick();
        #1;
        chk("bp_msg2", b0.send_msg, 1);
        tick();
        #1;
        chk("bp_msg3", b0.send_msg, 0);
        chk("bp_rdy3", b0.recv_rdy, 1);
        tick();
        #1;
        chk("bp_idle", b0.send_val, 0);

        // Back-to-back 0xB4 then 0x5A with valid held high: no bubble
        accept("b2b", 8'hB4, 1'b1);
        begin
            logic [1:0] e [8];
            e[0] = 2'd2; e[1] = 2'd3; e[2] = 2'd1; e[3] = 2'd0;
            e[4] = 2'd1; e[5] = 2'd1; e[6] = 2'd2; e[7] = 2'd2;
            for (int i = 0; i < 8; i++) begin
                b0.recv_val  = (i <= 3);
                b0.recv_msg  = 8'h5A;
                b0.msb_first = 1'b1;
                #1;
                chk($sformatf("b2b_val%0d", i), b0.send_val, 1);
                chk($sformatf("b2b_msg%0d", i), b0.send_msg, e[i]);
                chk($sformatf("b2b_rdy%0d", i), b0.recv_rdy, (i == 3 || i == 7));
                tick();
            end
            b0.recv_val = 1'b0;
            #1;
            chk("b2b_idle", b0.send_val, 0);
        end

        // Reset while the beat carrying 3 is on the bus
        accept("rmw", 8'hB4, 1'b1);
        tick();
        #1;
        chk("rmw_msg", b0.send_msg, 3);
        reset = 1'b1;
        tick();
        #1;
        chk("rmw_val", b0.send_val, 0);
        chk("rmw_zero", b0.send_msg, 0);
        chk("rmw_rdy", b0.recv_rdy, 0);
        tick();
        #1;
        chk("rmw_val_hold", b0.send_val, 0);
        reset = 1'b0;
        accept("ff", 8'hFF, 1'b1);
        beats("ff", 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);

        // Degenerate single-beat instance: one word per cycle under streaming
        b1.send_rdy  = 1'b1;
        b1.recv_val  = 1'b1;
        b1.recv_msg  = 8'hC3;
        #1;
        chk("deg_rdy0", b1.recv_rdy, 1);
        tick();
        b1.recv_msg = 8'h3C;
        #1;
        chk("deg_val0", b1.send_val, 1);
        chk("deg_msg0", b1.send_msg, 8'hC3);
        chk("deg_rdy1", b1.recv_rdy, 1);
`ifdef SERIALIZER_LAST_EN
        chk("deg_last0", b1.send_last, 1);
`endif
        tick();
        b1.recv_val = 1'b0;
        #1;
        chk("deg_val1", b1.send_val, 1);
        chk("deg_msg1", b1.send_msg, 8'h3C);
        tick();
        #1;
        chk("deg_idle", b1.send_val, 0);
        chk("deg_idle_rdy", b1.recv_rdy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
